// File: rtl/cic_pkg.sv
// Shared constant helpers for the CIC decimator.
//   clog2         : ceiling log2, usable in parameter expressions
//   cic_reg_width : accumulator width that holds the full CIC gain without loss
package cic_pkg;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned result;
    longint unsigned pow;
    result = 0;
    pow    = 64'd1;
    while (pow < value) begin
      pow = pow << 1;
      result++;
    end
    return result;
  endfunction

  function automatic int unsigned cic_reg_width(input int unsigned data_w,
                                                input int unsigned stages,
                                                input int unsigned max_dec,
                                                input int unsigned diff_delay);
    return data_w + stages * clog2(64'(max_dec) * 64'(diff_delay));
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-stream bundle between the ADC/mixer front end and the CIC decimator.
//   master : sample source (drives in_valid/data_in/decimation/gain)
//   slave  : decimator (drives out_valid/data_out/data_clk/sat)
interface cic_decimator_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned OUT_WIDTH  = 12,
  parameter int unsigned RATE_WIDTH = cic_pkg::clog2(64'(16385)),
  parameter int unsigned GAIN_WIDTH = 8
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic [RATE_WIDTH-1:0]        decimation;
  logic [GAIN_WIDTH-1:0]        gain;
  logic                         out_valid;
  logic signed [OUT_WIDTH-1:0]  data_out;
  logic                         data_clk;
  logic                         sat;

  modport master (output in_valid, data_in, decimation, gain,
                  input  out_valid, data_out, data_clk, sat);
  modport slave  (input  in_valid, data_in, decimation, gain,
                  output out_valid, data_out, data_clk, sat);
endinterface

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: y = x - x delayed DIFF_DELAY strobes.
//   clk, rst : clock, synchronous active-high reset
//   in_stb/x : strobe and input sample from the previous stage
//   out_stb/y: strobe and difference, one clock later
module cic_comb_stage #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DIFF_DELAY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_stb,
  input  logic signed [WIDTH-1:0] x,
  output logic                    out_stb,
  output logic signed [WIDTH-1:0] y
);
  logic signed [WIDTH-1:0] dly [DIFF_DELAY];

  // Delay line advances only on this stage's own strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb <= 1'b0;
      y       <= '0;
      for (int i = 0; i < int'(DIFF_DELAY); i++) dly[i] <= '0;
    end else begin
      out_stb <= in_stb;
      if (in_stb) begin
        y      <= x - dly[DIFF_DELAY-1];
        dly[0] <= x;
        for (int i = 1; i < int'(DIFF_DELAY); i++) dly[i] <= dly[i-1];
      end
    end
  end
endmodule

// File: rtl/cic_decimator.sv
// Multi-stage CIC decimator with runtime ratio, gain shift and saturation.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of cic_decimator_if
//              in_valid/data_in  input samples
//              decimation/gain   ratio request (latched per period), output shift
//              out_valid/data_out/sat  decimated sample strobe, value, clamp flag
//              data_clk          output-rate square wave
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned OUT_WIDTH      = 12,
  parameter int unsigned STAGES         = 5,
  parameter int unsigned MAX_DECIMATION = 16384,
  parameter int unsigned DIFF_DELAY     = 1,
  parameter int unsigned GAIN_WIDTH     = 8
) (
  input logic           clk,
  input logic           rst,
  cic_decimator_if.slave bus
);
  localparam int unsigned RATE_WIDTH     = clog2(64'(MAX_DECIMATION) + 64'd1);
  localparam int unsigned REGISTER_WIDTH = cic_reg_width(DATA_WIDTH, STAGES, MAX_DECIMATION, DIFF_DELAY);
  localparam int unsigned SHIFT_MAX      = REGISTER_WIDTH - OUT_WIDTH;
  localparam int unsigned WARMUP         = STAGES * DIFF_DELAY;
  localparam int unsigned WARM_W         = clog2(64'(WARMUP) + 64'd1);

  typedef logic signed [REGISTER_WIDTH-1:0] cic_acc_t;

  localparam cic_acc_t OUT_MAX = cic_acc_t'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam cic_acc_t OUT_MIN = ~OUT_MAX;

  logic signed [DATA_WIDTH-1:0] din_c;
  logic [GAIN_WIDTH-1:0]        gain_c;
  logic [RATE_WIDTH-1:0]        r_req_c, r_cur_c, r_active, count;
  logic                         ratio_loaded, wrap_c, fall_c;
  cic_acc_t                     integ [STAGES];
  cic_acc_t                     cap_data;
  logic                         cap_stb;
  cic_acc_t                     comb_x [STAGES+1];
  logic [STAGES:0]              comb_stb;
  logic [WARM_W-1:0]            warm_cnt;
  logic [31:0]                  shift_c;
  cic_acc_t                     scaled_c;
  logic                         sat_hi_c, sat_lo_c;
  logic signed [OUT_WIDTH-1:0]  clamped_c;

  assign din_c  = bus.data_in;
  assign gain_c = bus.gain;

  // Requested ratio clamped into 2..MAX_DECIMATION.
  always_comb begin
    r_req_c = bus.decimation;
    if (bus.decimation < RATE_WIDTH'(2))                   r_req_c = RATE_WIDTH'(2);
    else if (bus.decimation > RATE_WIDTH'(MAX_DECIMATION)) r_req_c = RATE_WIDTH'(MAX_DECIMATION);
  end

  // Until the first clock after reset the ratio comes straight from the request.
  assign r_cur_c = ratio_loaded ? r_active : r_req_c;
  assign wrap_c  = bus.in_valid && (count == r_cur_c - RATE_WIDTH'(1));
  assign fall_c  = bus.in_valid && !wrap_c && (count + RATE_WIDTH'(1) == (r_cur_c >> 1));

  // Sample counter and per-period ratio latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      r_active     <= '0;
      ratio_loaded <= 1'b0;
    end else begin
      if (!ratio_loaded) begin
        ratio_loaded <= 1'b1;
        r_active     <= r_req_c;
      end
      if (bus.in_valid) begin
        if (wrap_c) begin
          count    <= '0;
          r_active <= r_req_c;
        end else begin
          count <= count + RATE_WIDTH'(1);
        end
      end
    end
  end

  // Integrator cascade, two's-complement wrap is intentional.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) integ[k] <= '0;
    end else if (bus.in_valid) begin
      integ[0] <= integ[0] + cic_acc_t'(din_c);
      for (int k = 1; k < int'(STAGES); k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Decimation point: snapshot the last integrator and launch the comb strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_stb  <= 1'b0;
      cap_data <= '0;
    end else begin
      cap_stb <= wrap_c;
      if (wrap_c) cap_data <= integ[STAGES-1];
    end
  end

  assign comb_x[0]   = cap_data;
  assign comb_stb[0] = cap_stb;

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_comb
    cic_comb_stage #(
      .WIDTH      (REGISTER_WIDTH),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_comb (
      .clk     (clk),
      .rst     (rst),
      .in_stb  (comb_stb[g]),
      .x       (comb_x[g]),
      .out_stb (comb_stb[g+1]),
      .y       (comb_x[g+1])
    );
  end

  // Gain as a reduced right shift, then clamp to the output range.
  always_comb begin
    shift_c   = (32'(gain_c) >= 32'(SHIFT_MAX)) ? 32'd0 : 32'(SHIFT_MAX) - 32'(gain_c);
    scaled_c  = comb_x[STAGES] >>> shift_c;
    sat_hi_c  = scaled_c > OUT_MAX;
    sat_lo_c  = scaled_c < OUT_MIN;
    clamped_c = scaled_c[OUT_WIDTH-1:0];
    if (sat_hi_c)      clamped_c = OUT_MAX[OUT_WIDTH-1:0];
    else if (sat_lo_c) clamped_c = OUT_MIN[OUT_WIDTH-1:0];
  end

  // Output register; the first WARMUP strobes only prime the comb delay lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.sat       <= 1'b0;
      bus.data_clk  <= 1'b0;
      warm_cnt      <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (comb_stb[STAGES]) begin
        if (warm_cnt != WARM_W'(WARMUP)) begin
          warm_cnt <= warm_cnt + WARM_W'(1);
        end else begin
          bus.out_valid <= 1'b1;
          bus.data_out  <= clamped_c;
          bus.sat       <= sat_hi_c | sat_lo_c;
        end
      end
      if (comb_stb[STAGES])  bus.data_clk <= 1'b1;
      else if (fall_c)       bus.data_clk <= 1'b0;
    end
  end
endmodule
